// File: rtl/ram_fifo_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO controller.
// Defaults match a 256 x 32 dual-port SRAM with byte masks.
package ram_fifo_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 8;
  localparam int NUM_WMASKS = 4;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  localparam logic [NUM_WMASKS-1:0] WMASK_ALL = '1;

  // Room for another read once buffered, inflight and leaving words settle.
  function automatic logic rd_room(
    input logic [1:0] ob,
    input logic       infl,
    input logic       pop
  );
    logic [2:0] occ;
    occ = 3'(ob) + 3'(infl) - 3'(pop);
    return occ < 3'd2;
  endfunction

endpackage

// File: rtl/ram_fifo_obuf.sv
// Two-entry output buffer with a registered head word.
// Loaded from RAM read data, drained by the pop stream.
module ram_fifo_obuf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic [1:0]            ob_count
);

  logic [DATA_WIDTH-1:0] tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      ob_count <= 2'd0;
    end else begin
      unique case (ob_count)
        2'd0: begin
          if (load) begin
            data     <= load_data;
            ob_count <= 2'd1;
          end
        end
        2'd1: begin
          if (load && pop) begin
            data <= load_data;
          end else if (load) begin
            tail     <= load_data;
            ob_count <= 2'd2;
          end else if (pop) begin
            ob_count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            data <= tail;
            if (load) tail <= load_data;
            else ob_count <= 2'd1;
          end
        end
        default: ob_count <= 2'd0;
      endcase
    end
  end

  assign valid = (ob_count != 2'd0);

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over an external 1W/1R synchronous SRAM.
// Reads are prefetched into a 2-entry buffer for full throughput.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = ram_fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_fifo_pkg::ADDR_WIDTH,
  parameter int NUM_WMASKS = ram_fifo_pkg::NUM_WMASKS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  ram_csb0,
  output logic                  ram_web0,
  output logic [NUM_WMASKS-1:0] ram_wmask0,
  output logic [ADDR_WIDTH-1:0] ram_addr0,
  output logic [DATA_WIDTH-1:0] ram_din0,
  output logic                  ram_csb1,
  output logic [ADDR_WIDTH-1:0] ram_addr1,
  input  logic [DATA_WIDTH-1:0] ram_dout1
);

  import ram_fifo_pkg::*;

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE =
    (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE =
    ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  inflight;
  logic [1:0]            ob_count;
  logic                  ob_valid;
  logic                  push;
  logic                  pop;
  logic                  rd_en;

  assign count   = rst ? '0 : count_q;
  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign s_ready = !rst && !full;
  assign m_valid = !rst && ob_valid;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  // ram_cnt only counts words written in earlier cycles,
  // so a read never targets the address being written now.
  assign rd_en = !rst && (ram_cnt != '0)
              && rd_room(ob_count, inflight, pop);

  assign ram_csb0   = !push;
  assign ram_web0   = !push;
  assign ram_wmask0 = push ? '1 : '0;
  assign ram_addr0  = wr_ptr;
  assign ram_din0   = s_data;
  assign ram_csb1   = !rd_en;
  assign ram_addr1  = rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !rd_en) ram_cnt <= ram_cnt + CNT_ONE;
      else if (!push && rd_en) ram_cnt <= ram_cnt - CNT_ONE;
      if (push && !pop) count_q <= count_q + CNT_ONE;
      else if (!push && pop) count_q <= count_q - CNT_ONE;
    end
  end

  ram_fifo_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .load     (inflight),
    .load_data(ram_dout1),
    .pop      (pop),
    .data     (m_data),
    .valid    (ob_valid),
    .ob_count (ob_count)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomised bench for ram_fifo_ctrl with a queue reference model.
// A behavioural sync SRAM model sits on the RAM ports.
module tb_ram_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NW = 4;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          ram_csb0;
  logic          ram_web0;
  logic [NW-1:0] ram_wmask0;
  logic [AW-1:0] ram_addr0;
  logic [DW-1:0] ram_din0;
  logic          ram_csb1;
  logic [AW-1:0] ram_addr1;
  logic [DW-1:0] ram_dout1;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_WMASKS(NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ram_csb0  (ram_csb0),
    .ram_web0  (ram_web0),
    .ram_wmask0(ram_wmask0),
    .ram_addr0 (ram_addr0),
    .ram_din0  (ram_din0),
    .ram_csb1  (ram_csb1),
    .ram_addr1 (ram_addr1),
    .ram_dout1 (ram_dout1)
  );

  logic [DW-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (!ram_csb0 && !ram_web0) mem[ram_addr0] <= ram_din0;
    if (!ram_csb1) ram_dout1 <= mem[ram_addr1];
  end

  logic [DW-1:0] q[$];
  int checks = 0;
  int passes = 0;

  logic          o_rdy, o_vld, o_full, o_empty;
  logic [DW-1:0] o_dat;
  logic [AW:0]   o_cnt;
  logic          did_push, did_pop;

  task automatic drive(input logic sv, input logic [DW-1:0] sd,
                       input logic mr);
    @(negedge clk);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    #1;
    o_rdy    = s_ready;
    o_vld    = m_valid;
    o_dat    = m_data;
    o_cnt    = count;
    o_full   = full;
    o_empty  = empty;
    did_push = sv && o_rdy;
    did_pop  = o_vld && mr;
  endtask

  task automatic upd(input logic [DW-1:0] sd);
    if (did_pop && q.size() > 0) void'(q.pop_front());
    if (did_push) q.push_back(sd);
  endtask

  function automatic logic [DW-1:0] front();
    return (q.size() > 0) ? q[0] : '0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = '1; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({s_ready, m_valid, full, empty, ram_csb0, ram_csb1}
        !== 6'b000111)
      $display("FAIL reset_flags got %b want 000111",
        {s_ready, m_valid, full, empty, ram_csb0, ram_csb1});
    else passes++;
    checks++;
    if (count !== '0) $display("FAIL reset_count got %0d want 0", count);
    else passes++;
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    q.delete();
    #1;
    checks++;
    if (s_ready !== 1'b1 || empty !== 1'b1)
      $display("FAIL post_reset got rdy=%b empty=%b want 1 1",
        s_ready, empty);
    else passes++;
  endtask

  task automatic test_first_word();
    logic [DW-1:0] w;
    w = 32'h1111_1111;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(k == 0, w, 1'b1);
      checks++;
      if (o_vld !== (k == 3))
        $display("FAIL first_valid cyc %0d got %b want %b",
          k, o_vld, (k == 3));
      else passes++;
      checks++;
      if (o_cnt !== ((k >= 1 && k <= 3) ? 9'd1 : 9'd0))
        $display("FAIL first_count cyc %0d got %0d", k, o_cnt);
      else passes++;
      if (k == 3) begin
        checks++;
        if (o_dat !== w)
          $display("FAIL first_data got %h want %h", o_dat, w);
        else passes++;
      end
      if (k == 0) begin
        checks++;
        if ({ram_csb0, ram_web0, ram_wmask0} !== 6'b001111
            || ram_addr0 !== '0 || ram_din0 !== w)
          $display("FAIL wr_port got %b%b %b a=%h d=%h",
            ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0);
        else passes++;
      end
      if (k == 1) begin
        checks++;
        if (ram_csb0 !== 1'b1)
          $display("FAIL wr_idle got csb0=%b want 1", ram_csb0);
        else passes++;
      end
      upd(w);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, DW'(i), 1'b0);
      checks++;
      if (o_rdy !== 1'b1 || o_cnt !== 9'(q.size()))
        $display("FAIL fill_%0d got rdy=%b cnt=%0d want 1 %0d",
          i, o_rdy, o_cnt, q.size());
      else passes++;
      upd(DW'(i));
    end
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (o_full !== 1'b1 || o_rdy !== 1'b0 || o_cnt !== 9'd256)
      $display("FAIL full got full=%b rdy=%b cnt=%0d want 1 0 256",
        o_full, o_rdy, o_cnt);
    else passes++;
    upd(32'hDEAD_BEEF);
    drive(1'b1, 32'hDEAD_BEEF, 1'b1);
    checks++;
    if (o_cnt !== 9'd256 || !o_vld || o_dat !== front())
      $display("FAIL full_pop got cnt=%0d v=%b d=%h want 256 1 %h",
        o_cnt, o_vld, o_dat, front());
    else passes++;
    upd(32'hDEAD_BEEF);
    drive(1'b0, '0, 1'b0);
    checks++;
    if (o_cnt !== 9'd255 || o_full !== 1'b0 || o_rdy !== 1'b1)
      $display("FAIL after_full got cnt=%0d full=%b rdy=%b",
        o_cnt, o_full, o_rdy);
    else passes++;
    upd('0);
    for (int k = 0; k < 600 && q.size() > 0; k++) begin
      drive(1'b0, '0, 1'b1);
      if (did_pop) begin
        checks++;
        if (o_dat !== front())
          $display("FAIL fill_drain got %h want %h", o_dat, front());
        else passes++;
      end
      upd('0);
    end
    checks++;
    if (q.size() != 0)
      $display("FAIL fill_drain_left got %0d want 0", q.size());
    else passes++;
  endtask

  task automatic test_stream();
    int npop, first, last;
    logic [DW-1:0] d;
    npop = 0; first = -1; last = -1;
    do_reset();
    for (int k = 0; k < 620; k++) begin
      d = $urandom;
      drive(k < 600, d, 1'b1);
      if (k < 600) begin
        checks++;
        if (o_rdy !== 1'b1)
          $display("FAIL stream_rdy cyc %0d got %b want 1", k, o_rdy);
        else passes++;
      end
      if (did_pop) begin
        checks++;
        if (o_dat !== front())
          $display("FAIL stream_data got %h want %h", o_dat, front());
        else passes++;
        npop++;
        if (first < 0) first = k;
        last = k;
      end
      upd(d);
    end
    checks++;
    if (npop != 600 || first != 3 || last != 602)
      $display("FAIL stream_rate got n=%0d first=%0d last=%0d want 600 3 602",
        npop, first, last);
    else passes++;
  endtask

  task automatic test_toggle();
    int npush, npop;
    logic stall;
    logic [DW-1:0] hold, d;
    npush = 0; npop = 0; stall = 1'b0; hold = '0;
    do_reset();
    for (int k = 0; k < 500; k++) begin
      d = $urandom;
      drive(npush < 100, d, (k % 2) == 0);
      if (stall) begin
        checks++;
        if (o_vld !== 1'b1 || o_dat !== hold)
          $display("FAIL hold got v=%b d=%h want 1 %h", o_vld, o_dat, hold);
        else passes++;
      end
      checks++;
      if (o_cnt !== 9'(q.size()))
        $display("FAIL toggle_cnt got %0d want %0d", o_cnt, q.size());
      else passes++;
      if (did_pop) begin
        checks++;
        if (o_dat !== front())
          $display("FAIL toggle_data got %h want %h", o_dat, front());
        else passes++;
        npop++;
      end
      if (did_push) npush++;
      stall = o_vld && (k % 2) != 0;
      hold  = o_dat;
      upd(d);
      if (npush == 100 && q.size() == 0) break;
    end
    checks++;
    if (npop != 100 || q.size() != 0)
      $display("FAIL toggle_total got %0d want 100", npop);
    else passes++;
  endtask

  task automatic test_mid_reset();
    logic found, prev_rd, got;
    logic [DW-1:0] d;
    found = 1'b0; prev_rd = 1'b0; got = 1'b0;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      d = $urandom;
      drive(1'b1, d, (k % 2) == 1);
      if (o_cnt == 9'd5 && prev_rd) begin
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        found = 1'b1;
        break;
      end
      prev_rd = !ram_csb1;
      upd(d);
    end
    checks++;
    if (!found) $display("FAIL midrst_setup got none want cnt5+inflight");
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    #1;
    checks++;
    if (count !== '0 || m_valid !== 1'b0)
      $display("FAIL midrst_clear got cnt=%0d v=%b want 0 0",
        count, m_valid);
    else passes++;
    for (int k = 0; k < 10; k++) begin
      drive(k == 0, 32'hA5A5_A5A5, 1'b1);
      if (did_pop) begin
        got = 1'b1;
        checks++;
        if (o_dat !== 32'hA5A5_A5A5)
          $display("FAIL midrst_first got %h want a5a5a5a5", o_dat);
        else passes++;
        break;
      end
      upd(32'hA5A5_A5A5);
    end
    checks++;
    if (!got) $display("FAIL midrst_pop got none want 1");
    else passes++;
  endtask

  task automatic test_random();
    logic sv, mr;
    logic [DW-1:0] d;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      d = $urandom;
      if (k < 1200) begin
        sv = ($urandom_range(9) != 0); mr = ($urandom_range(4) == 0);
      end else if (k < 2200) begin
        sv = $urandom_range(1) == 1; mr = $urandom_range(1) == 1;
      end else begin
        sv = ($urandom_range(9) == 0); mr = ($urandom_range(9) != 0);
      end
      drive(sv, d, mr);
      checks++;
      if (o_cnt !== 9'(q.size())
          || o_rdy !== (q.size() < DEPTH)
          || o_full !== (q.size() == DEPTH)
          || o_empty !== (q.size() == 0))
        $display("FAIL rand_state cyc %0d got c=%0d r=%b f=%b e=%b want c=%0d",
          k, o_cnt, o_rdy, o_full, o_empty, q.size());
      else passes++;
      if (o_vld) begin
        checks++;
        if (q.size() == 0) $display("FAIL rand_valid got 1 want 0");
        else passes++;
      end
      if (did_pop) begin
        checks++;
        if (o_dat !== front())
          $display("FAIL rand_data got %h want %h", o_dat, front());
        else passes++;
      end
      upd(d);
    end
    for (int k = 0; k < 600 && q.size() > 0; k++) begin
      drive(1'b0, '0, 1'b1);
      if (did_pop) begin
        checks++;
        if (o_dat !== front())
          $display("FAIL rand_drain got %h want %h", o_dat, front());
        else passes++;
      end
      upd('0);
    end
    checks++;
    if (q.size() != 0)
      $display("FAIL rand_left got %0d want 0", q.size());
    else passes++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got no finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    test_reset();
    test_first_word();
    test_fill();
    test_stream();
    test_toggle();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width.
REQ-002 Parameter ADDR_WIDTH, default 8: RAM address width; DEPTH = 2**ADDR_WIDTH = 256.
REQ-003 Parameter NUM_WMASKS, default 4: byte-lane count of the RAM write mask.
REQ-004 clk  in  1: the only clock; drives both RAM ports (clk0, clk1).
REQ-005 rst  in  1: reset, synchronous, active-high.
REQ-006 s_valid  in  1 / s_ready  out  1 / s_data  in  DATA_WIDTH: push stream.
REQ-007 m_valid  out  1 / m_ready  in  1 / m_data  out  DATA_WIDTH: pop stream.
REQ-008 count  out  ADDR_WIDTH+1: total entries held. full  out  1. empty  out  1.
REQ-009 ram_csb0, ram_web0  out  1 / ram_wmask0  out  NUM_WMASKS / ram_addr0  out  ADDR_WIDTH / ram_din0  out  DATA_WIDTH: RAM port 0, write-only use.
REQ-010 ram_csb1  out  1 / ram_addr1  out  ADDR_WIDTH / ram_dout1  in  DATA_WIDTH: RAM port 1, read.

Function
REQ-011 Push accepted when s_valid && s_ready; s_ready = !full, with no bypass when a pop occurs in the same cycle.
REQ-012 In a push cycle, drive ram_csb0=0, ram_web0=0, ram_wmask0=all ones, ram_addr0=wr_ptr, ram_din0=s_data combinationally; otherwise ram_csb0=1, ram_web0=1.
REQ-013 wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap from DEPTH-1 to 0 naturally.
REQ-014 A pushed word becomes readable one cycle after its push cycle; no read of an address is issued in the same cycle that address is written.
REQ-015 Issue a read (ram_csb1=0, ram_addr1=rd_ptr, rd_ptr+1) when readable_count>0 && (ob_count + inflight - pop) < 2; otherwise ram_csb1=1.
REQ-016 Read data from a read issued in cycle N is taken from ram_dout1 in cycle N+1 and loaded into the 2-entry output buffer at the end of N+1.
REQ-017 m_valid = output buffer non-empty; m_data = head entry, registered; pop = m_valid && m_ready.
REQ-018 First-word latency: push in cycle N gives m_valid=1 in cycle N+3.
REQ-019 Steady-state throughput is 1 word/cycle with continuous s_valid and m_ready.
REQ-020 count = RAM-resident + inflight + ob_count; it is incremented on push and decremented on pop; simultaneous push and pop leave it unchanged.
REQ-021 full = (count == DEPTH); empty = (count == 0).
REQ-022 m_ready low: the buffer holds its head stable and m_valid stays high until the pop (no drop, no reorder).
REQ-023 Ordering: words pop in exact push order across pointer wrap.

Reset
REQ-024 While rst=1: wr_ptr=0, rd_ptr=0, count=0, inflight=0, ob_count=0, m_valid=0, empty=1, full=0, s_ready=0, ram_csb0=1, ram_csb1=1.
REQ-025 Reset asserted mid-operation discards all held and inflight words; ram_dout1 returning after reset is ignored.
REQ-026 RAM contents are not cleared; reads never return an address not written since reset.

Structure
REQ-027 Package ram_fifo_pkg holds DATA_WIDTH, ADDR_WIDTH, NUM_WMASKS, DEPTH, and a WMASK_ALL constant.
REQ-028 One sub-module, ram_fifo_obuf: the 2-entry output buffer with load, pop and ob_count.
REQ-029 All control state lives in ram_fifo_ctrl; the RAM instance is external.

Verification
REQ-030 After reset, push 0x11111111 in cycle 0 with m_ready=1 -> m_valid=1 and m_data=0x11111111 in cycle 3; count returns to 0 in cycle 4.
REQ-031 Push 256 words 0..255 with m_ready=0 -> full=1 and s_ready=0 after the 256th push; a 257th push is refused and count=256.
REQ-032 Continuous push and pop of 600 words -> 1 word/cycle after the 3-cycle fill, in-order data across two pointer wraps, zero drops.
REQ-033 m_ready toggled 1010 with full throughput -> no lost or duplicated words; m_data stable while m_valid && !m_ready.
REQ-034 rst pulsed while count=5 and a read is inflight -> next cycle count=0, m_valid=0; a subsequent push of 0xA5A5A5A5 is the first word popped.
REQ-035 When count=256, push and pop in the same cycle -> pop succeeds, push refused, count=255.
